// File: rtl/control_unit_pkg.sv
// Shared decode constants and the packed control word for the ID stage.
// Latency: none (types and constants only).
// Backpressure: none.
package cpu_pkg;

    localparam int OPC_W = 5;

    localparam logic [OPC_W-1:0] OPC_ART  = 5'h00;
    localparam logic [OPC_W-1:0] OPC_LOG  = 5'h01;
    localparam logic [OPC_W-1:0] OPC_JMP  = 5'h02;
    localparam logic [OPC_W-1:0] OPC_BQE  = 5'h03;
    localparam logic [OPC_W-1:0] OPC_BNE  = 5'h04;
    localparam logic [OPC_W-1:0] OPC_CALL = 5'h05;
    localparam logic [OPC_W-1:0] OPC_RET  = 5'h06;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'h07;
    localparam logic [OPC_W-1:0] OPC_ST   = 5'h08;
    localparam logic [OPC_W-1:0] OPC_CRY  = 5'h09;
    localparam logic [OPC_W-1:0] OPC_IMM  = 5'h0A;

    // Field order is MSB first and matches the ID_* port order of control_unit.
    typedef struct packed {
        logic branch;
        logic regwrite;
        logic memtoreg;
        logic memread;
        logic memwrite;
        logic alusrc;
        logic aluop;
        logic regdist;
        logic branchtype;
        logic push;
        logic pop;
        logic ret;
        logic jump;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/control_unit_if.sv
// Decode-stage bus: opcode/hazard in, registered control signals out.
// Latency: none (wiring only).
// Backpressure: none; hazard is the only stall mechanism and is carried here.
interface control_unit_if;
    import cpu_pkg::*;

    logic [OPC_W-1:0] opcode;
    logic             hazard;

    logic ID_branch;
    logic ID_regwrite;
    logic ID_memtoreg;
    logic ID_memread;
    logic ID_memwrite;
    logic ID_alusrc;
    logic ID_aluop;
    logic ID_regdist;
    logic ID_branchtype;
    logic ID_push;
    logic ID_pop;
    logic ID_ret;
    logic ID_jump;

    // Decode stage side: supplies opcode and hazard, observes control outputs.
    modport master (
        output opcode, hazard,
        input  ID_branch, ID_regwrite, ID_memtoreg, ID_memread, ID_memwrite,
               ID_alusrc, ID_aluop, ID_regdist, ID_branchtype, ID_push,
               ID_pop, ID_ret, ID_jump
    );

    // Control unit side.
    modport slave (
        input  opcode, hazard,
        output ID_branch, ID_regwrite, ID_memtoreg, ID_memread, ID_memwrite,
               ID_alusrc, ID_aluop, ID_regdist, ID_branchtype, ID_push,
               ID_pop, ID_ret, ID_jump
    );

endinterface

// File: rtl/control_unit_decode.sv
// Pure combinational opcode to control-word mapping.
// Latency: 0 cycles (combinational).
// Backpressure: none.
module control_decode
    import cpu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl
);

    // Each opcode asserts only its own fields; unused opcodes fall through as NOP.
    always_comb begin
        ctrl = '0;
        unique case (opcode)
            OPC_ART, OPC_CRY: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdist  = 1'b1;
            end
            OPC_LOG: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdist  = 1'b1;
                ctrl.aluop    = 1'b1;
            end
            OPC_JMP: begin
                ctrl.jump = 1'b1;
            end
            OPC_BQE: begin
                ctrl.branch = 1'b1;
            end
            OPC_BNE: begin
                ctrl.branch     = 1'b1;
                ctrl.branchtype = 1'b1;
            end
            OPC_CALL: begin
                ctrl.jump = 1'b1;
                ctrl.push = 1'b1;
            end
            OPC_RET: begin
                ctrl.ret = 1'b1;
                ctrl.pop = 1'b1;
            end
            OPC_LD: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.alusrc   = 1'b1;
            end
            OPC_ST: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
            end
            OPC_IMM: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ID-stage control unit: decodes opcode into a registered control word.
// Latency: 1 cycle from opcode/hazard sampled at an edge to outputs.
// Backpressure: none; hazard=1 loads a bubble (all-zero word), reset overrides hazard.
module control_unit
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    control_unit_if.slave  bus
);

    ctrl_t dec_word;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .opcode (bus.opcode),
        .ctrl   (dec_word)
    );

    // Output register: reset first, then bubble on hazard, else the decoded word.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
        end else if (bus.hazard) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= dec_word;
        end
    end

    assign bus.ID_branch     = ctrl_q.branch;
    assign bus.ID_regwrite   = ctrl_q.regwrite;
    assign bus.ID_memtoreg   = ctrl_q.memtoreg;
    assign bus.ID_memread    = ctrl_q.memread;
    assign bus.ID_memwrite   = ctrl_q.memwrite;
    assign bus.ID_alusrc     = ctrl_q.alusrc;
    assign bus.ID_aluop      = ctrl_q.aluop;
    assign bus.ID_regdist    = ctrl_q.regdist;
    assign bus.ID_branchtype = ctrl_q.branchtype;
    assign bus.ID_push       = ctrl_q.push;
    assign bus.ID_pop        = ctrl_q.pop;
    assign bus.ID_ret        = ctrl_q.ret;
    assign bus.ID_jump       = ctrl_q.jump;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset, per-opcode decode, hazard, sweep.
// Latency: checks outputs 1 ns after the edge that loads them.
// Backpressure: none.
module tb_control_unit;

    logic clk;
    logic rst;

    control_unit_if bus ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [12:0] prev_exp;
    bit          have_prev = 1'b0;

    // Bit order, MSB first:
    // branch regwrite memtoreg memread memwrite alusrc aluop regdist branchtype push pop ret jump
    localparam logic [12:0] W_ZERO = 13'b0_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] W_ART  = 13'b0_1_0_0_0_0_0_1_0_0_0_0_0;
    localparam logic [12:0] W_LOG  = 13'b0_1_0_0_0_0_1_1_0_0_0_0_0;
    localparam logic [12:0] W_JMP  = 13'b0_0_0_0_0_0_0_0_0_0_0_0_1;
    localparam logic [12:0] W_BQE  = 13'b1_0_0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [12:0] W_BNE  = 13'b1_0_0_0_0_0_0_0_1_0_0_0_0;
    localparam logic [12:0] W_CALL = 13'b0_0_0_0_0_0_0_0_0_1_0_0_1;
    localparam logic [12:0] W_RET  = 13'b0_0_0_0_0_0_0_0_0_0_1_1_0;
    localparam logic [12:0] W_LD   = 13'b0_1_1_1_0_1_0_0_0_0_0_0_0;
    localparam logic [12:0] W_ST   = 13'b0_0_0_0_1_1_0_0_0_0_0_0_0;
    localparam logic [12:0] W_IMM  = 13'b0_1_0_0_0_1_0_0_0_0_0_0_0;

    function automatic logic [12:0] expected_word(input int op);
        case (op)
            0:  return W_ART;
            1:  return W_LOG;
            2:  return W_JMP;
            3:  return W_BQE;
            4:  return W_BNE;
            5:  return W_CALL;
            6:  return W_RET;
            7:  return W_LD;
            8:  return W_ST;
            9:  return W_ART;
            10: return W_IMM;
            default: return W_ZERO;
        endcase
    endfunction

    function automatic logic [12:0] observed();
        return {bus.ID_branch, bus.ID_regwrite, bus.ID_memtoreg, bus.ID_memread,
                bus.ID_memwrite, bus.ID_alusrc, bus.ID_aluop, bus.ID_regdist,
                bus.ID_branchtype, bus.ID_push, bus.ID_pop, bus.ID_ret, bus.ID_jump};
    endfunction

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply inputs on the falling edge, confirm the previous word still holds,
    // then check the newly loaded word just after the rising edge.
    task automatic step(input logic r, input logic h, input logic [4:0] op,
                        input logic [12:0] exp, input string tag);
        @(negedge clk);
        rst        = r;
        bus.hazard = h;
        bus.opcode = op;
        #1;
        if (have_prev) check({tag, "_hold"}, observed(), prev_exp);
        @(posedge clk);
        #1;
        check(tag, observed(), exp);
        prev_exp  = exp;
        have_prev = 1'b1;
    endtask

    initial begin
        logic [12:0] w;
        rst        = 1'b1;
        bus.hazard = 1'b0;
        bus.opcode = 5'h07;

        // Reset with LD presented clears everything.
        step(1'b1, 1'b0, 5'h07, W_ZERO, "reset_ld");
        // First edge with rst low decodes immediately.
        step(1'b0, 1'b0, 5'h07, W_LD,   "ld");
        step(1'b0, 1'b0, 5'h04, W_BNE,  "bne");
        step(1'b0, 1'b0, 5'h03, W_BQE,  "bqe");
        step(1'b0, 1'b0, 5'h05, W_CALL, "call");
        step(1'b0, 1'b0, 5'h06, W_RET,  "ret");
        step(1'b0, 1'b1, 5'h08, W_ZERO, "st_hazard");
        step(1'b0, 1'b0, 5'h08, W_ST,   "st");
        // Hazard and reset together: reset result is all zeros.
        step(1'b0, 1'b0, 5'h01, W_LOG,  "log");
        step(1'b1, 1'b1, 5'h01, W_ZERO, "rst_and_hazard");
        step(1'b0, 1'b0, 5'h0A, W_IMM,  "imm");
        // Mid-stream reset discards the opcode sampled at that edge.
        step(1'b1, 1'b0, 5'h02, W_ZERO, "rst_midstream");
        step(1'b0, 1'b0, 5'h02, W_JMP,  "jmp");

        // Opcode wiggling between edges must not disturb the outputs.
        @(negedge clk);
        bus.opcode = 5'h07;
        #1 check("glitch_ld", observed(), W_JMP);
        bus.opcode = 5'h05;
        #1 check("glitch_call", observed(), W_JMP);
        bus.opcode = 5'h00;
        @(posedge clk);
        #1 check("art_after_glitch", observed(), W_ART);
        prev_exp = W_ART;

        // Full opcode sweep, including the NOP range.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 5'(i), expected_word(i), $sformatf("sweep_%02h", i));
            w = observed();
            checks++;
            assert (!(w[9] && w[8]) && !(w[3] && w[2])) else begin
                errors++;
                $error("FAIL excl_%02h observed=%b expected=no memread+memwrite and no push+pop", i, w);
            end
        end

        // Hazard bubble on an opcode that would otherwise assert outputs.
        step(1'b0, 1'b1, 5'h00, W_ZERO, "art_hazard");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
